alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 212 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// MIPS-style ALU with an iterative multiplier/divider and architectural HI/LO.
// Single-cycle ops complete in one cycle; MULT/DIV variants take WIDTH steps.
//
// state  | meaning
// IDLE   | accepting requests, single-cycle ops complete here
// MUL    | shift-add multiply in progress, one step per cycle
// DIV    | restoring divide in progress, one step per cycle
// HALT   | HALT accepted, frozen until reset
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_sel,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             halted
);

  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HALT} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 accept;
  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, prod_fin;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_fin, rem_fin;

  assign accept = in_valid && (state_q == S_IDLE);

  // Operands are iterated as magnitudes; signs are reapplied at commit.
  always_comb begin
    signed_op = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    a_neg     = signed_op && input1[WIDTH-1];
    b_neg     = signed_op && input2[WIDTH-1];
    abs_a     = a_neg ? -input1 : input1;
    abs_b     = b_neg ? -input2 : input2;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fin  = neg_q ? -mul_next : mul_next;

    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    quo_fin   = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fin   = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    neg_d       = neg_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          case (op_sel)
            OP_ADDU: result_d = input1 + input2;
            OP_SUBU: result_d = input1 - input2;
            OP_AND:  result_d = input1 & input2;
            OP_OR:   result_d = input1 | input2;
            OP_XOR:  result_d = input1 ^ input2;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            OP_SLL:  result_d = input2 << shamt;
            OP_SRL:  result_d = input2 >> shamt;
            OP_SRA:  result_d = $signed(input2) >>> shamt;
            OP_MFHI: result_d = hi_q;
            OP_MFLO: result_d = lo_q;
            OP_MULT, OP_MULTU: begin
              out_valid_d = 1'b0;
              state_d     = S_MUL;
              cnt_d       = '0;
              acc_d       = {{WIDTH{1'b0}}, abs_a};
              opb_d       = abs_b;
              neg_d       = a_neg ^ b_neg;
            end
            OP_DIV, OP_DIVU: begin
              out_valid_d = 1'b0;
              state_d     = S_DIV;
              cnt_d       = '0;
              acc_d       = {{WIDTH{1'b0}}, abs_a};
              opb_d       = abs_b;
              // Divide-by-zero keeps the raw all-ones quotient.
              neg_d       = (a_neg ^ b_neg) && (|input2);
              neg_rem_d   = a_neg;
            end
            OP_HALT: begin
              out_valid_d = 1'b0;
              state_d     = S_HALT;
            end
            default: result_d = '0;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          hi_d        = prod_fin[2*WIDTH-1:WIDTH];
          lo_d        = prod_fin[WIDTH-1:0];
          result_d    = prod_fin[WIDTH-1:0];
          out_valid_d = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          hi_d        = rem_fin;
          lo_d        = quo_fin;
          result_d    = quo_fin;
          out_valid_d = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      neg_q       <= neg_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign halted    = (state_q == S_HALT);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): randomized ops against a
// plain-arithmetic reference model of the ALU and HI/LO registers.
module tb_alu_muldiv;

  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] SC_OPS [12] = '{OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_SLT,
                                         OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO};
  localparam logic [5:0] IT_OPS [4]  = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  localparam logic [5:0] BAD_OPS [5] = '{6'b000001, 6'b001000, 6'b100000, 6'b111110, 6'b010001};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op_sel = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic        out_valid;
  logic [31:0] result, hi, lo;
  logic        busy, halted;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .shamt(shamt), .input1(input1), .input2(input2),
    .out_valid(out_valid), .result(result), .hi(hi), .lo(lo),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] model_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    case (op)
      OP_ADDU: return a + b;
      OP_SUBU: return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return b << sh;
      OP_SRL:  return b >> sh;
      OP_SRA:  return 32'($signed(b) >>> sh);
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_muldiv(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    longint unsigned pu;
    case (op)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_MULTU: begin
        pu = 64'(a) * 64'(b);
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endtask

  // Issue a single-cycle op at a negedge; returns at the next negedge.
  task automatic sc_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output logic ov, output logic [31:0] res);
    in_valid = 1'b1; op_sel = op; input1 = a; input2 = b; shamt = sh;
    @(negedge clk);
    ov = out_valid; res = result;
    in_valid = 1'b0;
  endtask

  // Issue an iterative op; keeps in_valid high with junk while busy.
  // Returns at the negedge where out_valid is seen (lat = -1 on timeout).
  task automatic run_iter(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic [31:0] h,
                          output logic [31:0] l, output bit win_ok);
    lat = -1; res = '0; h = '0; l = '0; win_ok = 1'b1;
    in_valid = 1'b1; op_sel = op; input1 = a; input2 = b; shamt = 5'($urandom);
    @(negedge clk);
    op_sel = OP_ADDU; input1 = $urandom; input2 = $urandom;
    for (int j = 0; j < 40; j++) begin
      if (out_valid) begin
        lat = j; res = result; h = hi; l = lo;
        break;
      end
      if (in_ready || !busy) win_ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({out_valid, busy, halted, in_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_flags: got ov/busy/halted/ready=%b required 0001",
               {out_valid, busy, halted, in_ready});
    end
    n_tests++;
    if ({result, hi, lo} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_regs: got result=%h hi=%h lo=%h required all 0", result, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [3] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000};
    in_valid = 1'b1; op_sel = OP_ADDU; input1 = 32'd7; input2 = 32'd5; shamt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin op_sel = OP_SUBU; input1 = 32'd3; input2 = 32'd5; end
      if (i == 1) begin op_sel = OP_SRA; input1 = '0; input2 = 32'h8000_0000; shamt = 5'd4; end
      if (i == 2) in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got ov=%b ready=%b result=%h required ov=1 ready=1 result=%h",
                 i, out_valid, in_ready, result, exp_q[i]);
      end
    end
  endtask

  task automatic test_alu_random();
    logic ov;
    logic [31:0] res, a, b, exp;
    logic [5:0] op;
    logic [4:0] sh;
    for (int i = 0; i < 150; i++) begin
      op = SC_OPS[$urandom_range(0, 11)];
      a = rand_operand(); b = rand_operand(); sh = 5'($urandom);
      exp = model_alu(op, a, b, sh);
      sc_op(op, a, b, sh, ov, res);
      n_tests++;
      if (ov !== 1'b1 || res !== exp || hi !== m_hi || lo !== m_lo) begin
        n_fail++;
        $display("FAIL alu_random op=%b a=%h b=%h sh=%0d: got ov=%b res=%h hi=%h lo=%h required ov=1 res=%h hi=%h lo=%h",
                 op, a, b, sh, ov, res, hi, lo, exp, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_mult_fixed();
    int lat; logic [31:0] res, h, l; bit win_ok;
    run_iter(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, res, h, l, win_ok);
    model_muldiv(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    n_tests++;
    if (lat !== 32 || !win_ok) begin
      n_fail++;
      $display("FAIL mult_timing: got latency=%0d window_ok=%0d required latency=32 window_ok=1", lat, win_ok);
    end
    n_tests++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB || res !== 32'hFFFF_FFEB) begin
      n_fail++;
      $display("FAIL mult_neg3x7: got hi=%h lo=%h res=%h required hi=ffffffff lo=ffffffeb res=ffffffeb",
               h, l, res);
    end
  endtask

  task automatic test_div_fixed();
    int lat; logic [31:0] res, h, l; bit win_ok;
    logic [5:0]  ops [4] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd9, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] bs  [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh  [4] = '{32'hFFFF_FFFF, 32'd9, 32'd0, 32'hFFFF_FFFB};
    logic [31:0] el  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      run_iter(ops[i], as[i], bs[i], lat, res, h, l, win_ok);
      model_muldiv(ops[i], as[i], bs[i]);
      n_tests++;
      if (lat !== 32 || !win_ok || h !== eh[i] || l !== el[i] || res !== el[i]) begin
        n_fail++;
        $display("FAIL div_fixed[%0d]: got lat=%0d win=%0d hi=%h lo=%h res=%h required lat=32 win=1 hi=%h lo=%h res=%h",
                 i, lat, win_ok, h, l, res, eh[i], el[i], el[i]);
      end
    end
  endtask

  task automatic test_mfhi();
    int lat; logic [31:0] res, h, l; bit win_ok; logic ov;
    run_iter(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, h, l, win_ok);
    model_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    sc_op(OP_MFHI, $urandom, $urandom, '0, ov, res);
    n_tests++;
    if (lat !== 32 || ov !== 1'b1 || res !== 32'hFFFF_FFFE) begin
      n_fail++;
      $display("FAIL mfhi_after_multu: got lat=%0d ov=%b res=%h required lat=32 ov=1 res=fffffffe", lat, ov, res);
    end
    sc_op(OP_MFLO, $urandom, $urandom, '0, ov, res);
    n_tests++;
    if (ov !== 1'b1 || res !== 32'h1) begin
      n_fail++;
      $display("FAIL mflo_after_multu: got ov=%b res=%h required ov=1 res=00000001", ov, res);
    end
  endtask

  task automatic test_muldiv_random();
    int lat; logic [31:0] res, h, l, a, b; bit win_ok; logic [5:0] op;
    for (int i = 0; i < 40; i++) begin
      op = IT_OPS[$urandom_range(0, 3)];
      a = rand_operand(); b = rand_operand();
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      run_iter(op, a, b, lat, res, h, l, win_ok);
      model_muldiv(op, a, b);
      n_tests++;
      if (lat !== 32 || !win_ok || h !== m_hi || l !== m_lo || res !== m_lo) begin
        n_fail++;
        $display("FAIL muldiv_random op=%b a=%h b=%h: got lat=%0d win=%0d hi=%h lo=%h res=%h required lat=32 win=1 hi=%h lo=%h",
                 op, a, b, lat, win_ok, h, l, res, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_unknown();
    logic ov; logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      sc_op(BAD_OPS[i], $urandom, $urandom, 5'($urandom), ov, res);
      n_tests++;
      if (ov !== 1'b1 || res !== 32'h0 || hi !== m_hi || lo !== m_lo || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL unknown_op %b: got ov=%b res=%h hi=%h lo=%h ready=%b required ov=1 res=0 hi=%h lo=%h ready=1",
                 BAD_OPS[i], ov, res, hi, lo, in_ready, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit spurious = 1'b0;
    logic ov; logic [31:0] res;
    in_valid = 1'b1; op_sel = OP_DIVU; input1 = 32'd1000; input2 = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (out_valid) spurious = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1; in_valid = 1'b1; op_sel = OP_ADDU;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    m_hi = '0; m_lo = '0;
    n_tests++;
    if (out_valid !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got ov=%b hi=%h lo=%h ready=%b busy=%b required ov=0 hi=0 lo=0 ready=1 busy=0",
               out_valid, hi, lo, in_ready, busy);
    end
    for (int j = 0; j < 40; j++) begin
      if (out_valid) spurious = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (spurious) begin
      n_fail++;
      $display("FAIL reset_abort_quiet: got out_valid=1 during/after aborted DIVU required none");
    end
    sc_op(OP_MFLO, '0, '0, '0, ov, res);
    n_tests++;
    if (ov !== 1'b1 || res !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort_mflo: got ov=%b res=%h required ov=1 res=0", ov, res);
    end
    rst = 1'b1; in_valid = 1'b1; op_sel = OP_ADDU; input1 = 32'd1; input2 = 32'd1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_priority: got ov=%b result=%h required ov=0 result=0", out_valid, result);
    end
  endtask

  task automatic test_halt();
    bit bad = 1'b0;
    logic ov; logic [31:0] res;
    in_valid = 1'b1; op_sel = OP_HALT;
    @(negedge clk);
    n_tests++;
    if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter: got halted=%b ready=%b ov=%b required halted=1 ready=0 ov=0",
               halted, in_ready, out_valid);
    end
    op_sel = OP_ADDU; input1 = 32'd2; input2 = 32'd3;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL halt_hold: got activity while halted required halted=1 ready=0 ov=0 throughout");
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sc_op(OP_ADDU, 32'd2, 32'd3, '0, ov, res);
    n_tests++;
    if (halted !== 1'b0 || ov !== 1'b1 || res !== 32'd5) begin
      n_fail++;
      $display("FAIL halt_exit: got halted=%b ov=%b res=%h required halted=0 ov=1 res=5", halted, ov, res);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_back_to_back();
    test_alu_random();
    test_mult_fixed();
    test_div_fixed();
    test_mfhi();
    test_muldiv_random();
    test_alu_random();
    test_unknown();
    test_reset_abort();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
